// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream adapter.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned ADDR_WIDTH     = 4;
  localparam int unsigned MAX_RD_LATENCY = 3;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// stream_buf: DEPTH-entry circular buffer with occupancy count and head-of-queue data.
module stream_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DATA_WIDTH-1:0]        head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Pointers wrap at DEPTH, which need not be a power of two; count alone tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: credit-based prefetch into a local buffer, presented as valid/ready.
// Optional word counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                             clk_rd,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             empty,
  input  logic [DATA_WIDTH-1:0]            data_out,
  output logic                             rd_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]                      word_cnt
`endif
);

  import fifo_pkg::*;

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("fifo_rd_stream: RD_LATENCY %0d outside 1..%0d", RD_LATENCY, MAX_RD_LATENCY);
  end
  if (BUF_DEPTH < 2 || BUF_DEPTH > 16) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH %0d outside 2..16", BUF_DEPTH);
  end

  logic [RD_LATENCY-1:0] vld_sr;
  logic                  pop;
  logic                  capture;
  logic [OCC_W-1:0]      buf_count;

  // Credits cover in-flight plus buffered words, so a capture always finds a free slot.
  assign rd_en   = en & ~empty & (occupancy < OCC_FULL);
  assign pop     = m_valid & m_ready;
  assign capture = vld_sr[RD_LATENCY-1];
  assign m_valid = (buf_count != '0);

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr    <= '0;
      occupancy <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | RD_LATENCY'(rd_en);
      case ({rd_en, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk_rd),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (data_out),
    .pop       (pop),
    .count     (buf_count),
    .head_data (m_data)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream (RD_LATENCY=1, BUF_DEPTH=4) with a behavioural FIFO model.
module tb_fifo_rd_stream;

  logic       clk_rd = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       empty;
  logic [7:0] data_out;
  logic       rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [2:0] occupancy;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] word_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model: test writes fifo_data/wr_ptr, model owns rd_ptr/empty/data_out.
  logic [7:0] fifo_data [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr;

  // Monitor state, written only by the monitor.
  int        cyc    = 0;
  int        rd_cnt = 0;
  logic [7:0] rx [$];
  int        xfer_cyc [$];

  fifo_rd_stream #(
    .DATA_WIDTH (8),
    .RD_LATENCY (1),
    .BUF_DEPTH  (4)
  ) dut (
    .clk_rd    (clk_rd),
    .rst_n     (rst_n),
    .en        (en),
    .empty     (empty),
    .data_out  (data_out),
    .rd_en     (rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  always #5 clk_rd = ~clk_rd;

  always @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= wr_ptr;
      empty    <= 1'b1;
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= fifo_data[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
      empty    <= ((rd_ptr + 8'd1) == wr_ptr);
    end else begin
      empty    <= (rd_ptr == wr_ptr);
    end
  end

  always @(posedge clk_rd) begin
    cyc <= cyc + 1;
    if (rst_n && rd_en) rd_cnt <= rd_cnt + 1;
    if (rst_n && m_valid && m_ready) begin
      rx.push_back(m_data);
      xfer_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_load(input logic [7:0] word);
    fifo_data[wr_ptr] = word;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk_rd);
    rst_n = 1'b1;
    @(negedge clk_rd);
  endtask

  // Wait until rx holds at least target words; an expired budget counts as a failure.
  task automatic wait_rx(input int target, input int budget, input string tag);
    int n = 0;
    while (rx.size() < target && n < budget) begin
      @(negedge clk_rd);
      n++;
    end
    check(tag, 32'(rx.size() >= target), 32'd1);
  endtask

  initial begin
    int base;
    int rd_base;
    int n;

    // Reset state
    do_reset();
    check("rst_rd_en",   32'(rd_en),     32'd0);
    check("rst_m_valid", 32'(m_valid),   32'd0);
    check("rst_m_data",  32'(m_data),    32'd0);
    check("rst_occ",     32'(occupancy), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("rst_word_cnt", word_cnt, 32'd0);
`endif

    // Streaming 0x00..0x3F with sink always ready
    for (int i = 0; i < 64; i++) fifo_load(8'(i));
    @(negedge clk_rd);
    base    = rx.size();
    rd_base = rd_cnt;
    m_ready = 1'b1;
    en      = 1'b1;
    #1;
    check("stream_first_rd_en", 32'(rd_en), 32'd1);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk_rd);
      n++;
    end
    check("stream_latency", 32'(n), 32'd2);
    wait_rx(base + 64, 200, "stream_done");
    if (rx.size() >= base + 64) begin
      for (int i = 0; i < 64; i++) check("stream_data", 32'(rx[base+i]), 32'(i));
      check("stream_back_to_back", 32'(xfer_cyc[base+63] - xfer_cyc[base]), 32'd63);
    end
    repeat (4) @(negedge clk_rd);
    check("stream_rd_count", 32'(rd_cnt - rd_base), 32'd64);
    check("stream_drained_valid", 32'(m_valid), 32'd0);
    check("stream_drained_occ", 32'(occupancy), 32'd0);

    // Backpressure: sink stalled for 10 cycles
    do_reset();
    for (int i = 0; i < 16; i++) fifo_load(8'(i));
    @(negedge clk_rd);
    base    = rx.size();
    rd_base = rd_cnt;
    en      = 1'b1;
    repeat (10) @(negedge clk_rd);
    check("bp_rd_count", 32'(rd_cnt - rd_base), 32'd4);
    check("bp_occ",      32'(occupancy), 32'd4);
    check("bp_rd_en",    32'(rd_en),     32'd0);
    check("bp_m_valid",  32'(m_valid),   32'd1);
    check("bp_m_data",   32'(m_data),    32'h00);
    m_ready = 1'b1;
    wait_rx(base + 16, 100, "bp_done");
    if (rx.size() >= base + 16) begin
      for (int i = 0; i < 16; i++) check("bp_data", 32'(rx[base+i]), 32'(i));
    end
    repeat (4) @(negedge clk_rd);
    check("bp_total_rd", 32'(rd_cnt - rd_base), 32'd16);
    check("bp_total_rx", 32'(rx.size() - base), 32'd16);

    // FIFO holding only two words
    do_reset();
    fifo_load(8'hA5);
    fifo_load(8'h5A);
    @(negedge clk_rd);
    base    = rx.size();
    rd_base = rd_cnt;
    m_ready = 1'b1;
    en      = 1'b1;
    repeat (10) @(negedge clk_rd);
    check("empty_rd_count", 32'(rd_cnt - rd_base), 32'd2);
    check("empty_rx_count", 32'(rx.size() - base), 32'd2);
    if (rx.size() >= base + 2) begin
      check("empty_word0", 32'(rx[base]),   32'hA5);
      check("empty_word1", 32'(rx[base+1]), 32'h5A);
    end
    check("empty_m_valid", 32'(m_valid), 32'd0);
    check("empty_rd_en",   32'(rd_en),   32'd0);

    // en dropped one cycle after the first read
    do_reset();
    for (int i = 0; i < 4; i++) fifo_load(8'h10 + 8'(i));
    @(negedge clk_rd);
    base    = rx.size();
    rd_base = rd_cnt;
    m_ready = 1'b1;
    en      = 1'b1;
    @(negedge clk_rd);
    en = 1'b0;
    repeat (8) @(negedge clk_rd);
    check("endrop_rd_count", 32'(rd_cnt - rd_base), 32'd1);
    check("endrop_rx_count", 32'(rx.size() - base), 32'd1);
    if (rx.size() >= base + 1) check("endrop_word", 32'(rx[base]), 32'h10);
    check("endrop_rd_en", 32'(rd_en), 32'd0);
    en = 1'b1;
    repeat (10) @(negedge clk_rd);
    check("endrop_resume_rx", 32'(rx.size() - base), 32'd4);
    if (rx.size() >= base + 4) check("endrop_last", 32'(rx[base+3]), 32'h13);

    // Reset asserted mid-stream with three credits in use
    do_reset();
    for (int i = 0; i < 16; i++) fifo_load(8'h80 + 8'(i));
    @(negedge clk_rd);
    en = 1'b1;
    repeat (3) @(negedge clk_rd);
    check("midrst_occ_before", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("midrst_rd_en",   32'(rd_en),     32'd0);
    check("midrst_m_valid", 32'(m_valid),   32'd0);
    check("midrst_m_data",  32'(m_data),    32'd0);
    check("midrst_occ",     32'(occupancy), 32'd0);
    @(negedge clk_rd);
    rst_n = 1'b1;
    base    = rx.size();
    rd_base = rd_cnt;
    repeat (5) @(negedge clk_rd);
    check("midrst_idle_valid", 32'(m_valid), 32'd0);
    check("midrst_idle_rd",    32'(rd_cnt - rd_base), 32'd0);
    fifo_load(8'h77);
    fifo_load(8'h78);
    @(negedge clk_rd);
    m_ready = 1'b1;
    en      = 1'b1;
    repeat (8) @(negedge clk_rd);
    check("midrst_new_rx", 32'(rx.size() - base), 32'd2);
    if (rx.size() >= base + 2) check("midrst_new_last", 32'(rx[base+1]), 32'h78);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Word counter: 100 transfers, then wrap from all-ones
    do_reset();
    for (int i = 0; i < 100; i++) fifo_load(8'(i));
    @(negedge clk_rd);
    base    = rx.size();
    m_ready = 1'b1;
    en      = 1'b1;
    wait_rx(base + 100, 300, "cnt_done");
    repeat (3) @(negedge clk_rd);
    check("cnt_100", word_cnt, 32'd100);
    force dut.word_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.word_cnt;
    fifo_load(8'hEE);
    repeat (6) @(negedge clk_rd);
    check("cnt_wrap", word_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
